audio_stream_bridge: RTL

- Parametrised, multi-channel sample path between the I2S receive codec, the EQ processing chain and the I2S transmit codec.
- Replaces the single-register ADC latch and fixed repacking with:
  - channel-tagged capture into a FIFO;
  - a valid/ready handshake to the processor;
  - in-order result return;
  - per-channel DAC output registers with underrun/overflow accounting;
  - a bypass mode.
- Sits between the receive codec's sample_dat_o/mem_rdwr_o and the transmit codec's sample_dat_i/mem_rdwr_o.

---
 rtl/audio_bridge_pkg.sv | 12 +
 rtl/audio_stream_bridge_fifo.sv | 35 +++
 rtl/audio_stream_bridge.sv | 101 ++++++++++
 3 files changed

// File: rtl/audio_bridge_pkg.sv
// audio_bridge_pkg: shared helpers for the audio stream bridge
package audio_bridge_pkg;
  function automatic int chw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
  function automatic logic [63:0] pack_out(input logic [63:0] v, input int sh);
    return v << sh;
  endfunction
endpackage

// File: rtl/audio_stream_bridge_fifo.sv
// sync_fifo: register-based FIFO accepting a push into a full FIFO when a pop happens in the same cycle
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp[AW-1:0]];
  // storage and pointer update; the extra pointer bit separates full from empty
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wp[AW-1:0]] <= din;
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/audio_stream_bridge.sv
// audio_stream_bridge: channel-tagged capture, processor handshake, in-order return and per-channel DAC registers
module audio_stream_bridge
  import audio_bridge_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int IN_WIDTH   = 24,
  parameter int PROC_WIDTH = 16,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int CHW = chw(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OUT_WIDTH-1:0]  adc_data_i,
  input  logic                  adc_valid_i,
  input  logic                  adc_sync_i,
  input  logic                  bypass_i,
  output logic [PROC_WIDTH-1:0] proc_data_o,
  output logic [CHW-1:0]        proc_ch_o,
  output logic                  proc_valid_o,
  input  logic                  proc_ready_i,
  input  logic [PROC_WIDTH-1:0] res_data_i,
  input  logic                  res_valid_i,
  input  logic                  dac_request_i,
  input  logic                  dac_sync_i,
  output logic [OUT_WIDTH-1:0]  dac_data_o,
  output logic [15:0]           overflow_cnt_o,
  output logic [15:0]           underrun_cnt_o
);
  logic [CHW-1:0] rx_cnt, tx_cnt, rx_ch, tx_ch, cap_tag, res_ch;
  logic [IN_WIDTH-1:0] cap_smp, res_al;
  logic [IN_WIDTH-1:0] out_reg [NUM_CH];
  logic [NUM_CH-1:0] fresh, fresh_set;
  logic [OUT_WIDTH-1:0] dac_word;
  logic cap_full, cap_empty, cap_pop, tag_full, tag_empty;
  logic issue, byp_wr, res_ok, unused_hi;

  function automatic logic [CHW-1:0] nxt(input logic [CHW-1:0] c);
    return (c == CHW'(NUM_CH - 1)) ? '0 : c + 1'b1;
  endfunction

  assign unused_hi = &{1'b0, adc_data_i};
  assign rx_ch = adc_sync_i ? '0 : rx_cnt;
  assign tx_ch = dac_sync_i ? '0 : tx_cnt;
  assign proc_valid_o = !cap_empty && !tag_full && !bypass_i;
  assign proc_data_o = cap_smp[IN_WIDTH-1 -: PROC_WIDTH];
  assign proc_ch_o = cap_tag;
  assign issue = proc_valid_o && proc_ready_i;
  assign byp_wr = bypass_i && !cap_empty;
  assign cap_pop = bypass_i ? !cap_empty : issue;
  assign res_ok = res_valid_i && !tag_empty;
  assign res_al = IN_WIDTH'(pack_out(64'(res_data_i), IN_WIDTH - PROC_WIDTH));
  assign dac_word = OUT_WIDTH'(pack_out(64'(out_reg[tx_ch]), 0));

  sync_fifo #(.WIDTH(CHW + IN_WIDTH), .DEPTH(FIFO_DEPTH)) u_cap (
    .clk(clk), .reset(reset), .push(adc_valid_i), .pop(cap_pop),
    .din({rx_ch, adc_data_i[IN_WIDTH-1:0]}), .dout({cap_tag, cap_smp}),
    .full(cap_full), .empty(cap_empty)
  );

  sync_fifo #(.WIDTH(CHW), .DEPTH(FIFO_DEPTH)) u_tag (
    .clk(clk), .reset(reset), .push(issue), .pop(res_valid_i),
    .din(cap_tag), .dout(res_ch), .full(tag_full), .empty(tag_empty)
  );

  // a channel becomes fresh when a bypass sample or a returned result lands in it
  always_comb begin
    fresh_set = '0;
    for (int i = 0; i < NUM_CH; i++)
      fresh_set[i] = (byp_wr && cap_tag == CHW'(i)) || (res_ok && res_ch == CHW'(i));
  end

  // output registers; a set beats a DAC clear so a same-cycle write is never marked stale
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fresh <= '0;
      for (int i = 0; i < NUM_CH; i++) out_reg[i] <= '0;
    end else
      for (int i = 0; i < NUM_CH; i++) begin
        if (byp_wr && cap_tag == CHW'(i)) out_reg[i] <= cap_smp;
        else if (res_ok && res_ch == CHW'(i)) out_reg[i] <= res_al;
        if (fresh_set[i]) fresh[i] <= 1'b1;
        else if (dac_request_i && tx_ch == CHW'(i)) fresh[i] <= 1'b0;
      end

  // channel counters, DAC word and saturating drop/stale accounting
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_cnt <= '0;
      tx_cnt <= '0;
      dac_data_o <= '0;
      overflow_cnt_o <= '0;
      underrun_cnt_o <= '0;
    end else begin
      if (adc_valid_i) rx_cnt <= nxt(rx_ch);
      if (dac_request_i) tx_cnt <= nxt(tx_ch);
      if (dac_request_i) dac_data_o <= dac_word;
      if (adc_valid_i && cap_full && !cap_pop) overflow_cnt_o <= sat_inc16(overflow_cnt_o);
      if (dac_request_i && !fresh[tx_ch]) underrun_cnt_o <= sat_inc16(underrun_cnt_o);
    end
endmodule
